// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : pipe_ctrl_pkg                                            |
// | Purpose   : Shared state encoding and default sizing for the         |
// |             pipeline stall/flush sequencer.                          |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  // Default watchdog limit and counter width.
  localparam int c_def_timeout = 255;
  localparam int c_def_cnt_w   = 32;

  // Wait counter width covers the full TIMEOUT range 1..65535.
  localparam int c_wait_w      = 16;

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : sat_counter                                              |
// | Purpose   : WIDTH-bit incrementer that sticks at all-ones, with a    |
// |             count enable and an asynchronous active-low clear.       |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: hold at all-ones once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : pipe_stall_ctrl                                          |
// | Purpose   : Central stall/flush sequencer for the 5-stage pipeline.  |
// |             Merges data-cache miss, load-use hazard and taken branch |
// |             (in that priority) and watches the cache handshake for a |
// |             hung memory system.                                      |
// | Options   : PERF_CNT_EN - when defined, builds the memory-stall and  |
// |             load-use bubble counters; otherwise both read as zero.   |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = c_def_timeout,
  parameter int CNT_W   = c_def_cnt_w
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_i,
  input  logic             branch_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             mem_stall_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] hazard_cnt_o
);

  localparam logic [c_wait_w-1:0] c_timeout = TIMEOUT[c_wait_w-1:0];
  localparam logic [c_wait_w-1:0] c_one     = {{(c_wait_w-1){1'b0}}, 1'b1};

  state_t              state_q;
  state_t              state_d;
  logic [c_wait_w-1:0] wait_cnt_q;
  logic [c_wait_w-1:0] wait_cnt_d;

  // Hazard/branch response when memory is not holding the pipe.
  logic w_adv_hold;
  logic w_adv_flush;

  // Hazard outranks branch; a branch seen with a hazard is retried next cycle.
  always_comb begin
    w_adv_hold  = hazard_i;
    w_adv_flush = ~hazard_i & branch_i;
  end

  // Next-state, wait counter and combinational control outputs.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_stall_o   = 1'b0;
    ifid_stall_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    mem_stall_o  = 1'b0;
    error_o      = 1'b0;

    case (state_q)
      IDLE: begin
        pc_stall_o   = 1'b1;
        ifid_stall_o = 1'b1;
        mem_stall_o  = 1'b1;
        wait_cnt_d   = '0;
        if (start_i) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          pc_stall_o   = 1'b1;
          ifid_stall_o = 1'b1;
          mem_stall_o  = 1'b1;
          state_d      = MEM_WAIT;
          wait_cnt_d   = c_one;
        end else begin
          pc_stall_o   = w_adv_hold;
          ifid_stall_o = w_adv_hold;
          idex_flush_o = w_adv_hold;
          ifid_flush_o = w_adv_flush;
          wait_cnt_d   = '0;
        end
        if (!start_i) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end
      end

      MEM_WAIT: begin
        if (!mem_ack_i) begin
          pc_stall_o   = 1'b1;
          ifid_stall_o = 1'b1;
          mem_stall_o  = 1'b1;
          if (wait_cnt_q == c_timeout) begin
            state_d = ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + c_one;
          end
        end else begin
          // Refill done: the pipeline advances this cycle.
          pc_stall_o   = w_adv_hold;
          ifid_stall_o = w_adv_hold;
          idex_flush_o = w_adv_hold;
          ifid_flush_o = w_adv_flush;
          state_d      = RUN;
          wait_cnt_d   = '0;
        end
        if (!start_i) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end
      end

      default: begin
        // ERR is terminal until reset; start_i is ignored.
        pc_stall_o   = 1'b1;
        ifid_stall_o = 1'b1;
        mem_stall_o  = 1'b1;
        error_o      = 1'b1;
      end
    endcase
  end

  // State and watchdog registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PERF_CNT_EN
  logic w_stall_en;
  logic w_hazard_en;

  // Count only while the CPU is actually running.
  always_comb begin
    w_stall_en  = ((state_q == RUN) || (state_q == MEM_WAIT)) && mem_stall_o;
    w_hazard_en = idex_flush_o;
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (w_stall_en),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_hazard_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (w_hazard_en),
    .cnt_o (hazard_cnt_o)
  );
`else
  assign stall_cnt_o  = '0;
  assign hazard_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_pipe_stall_ctrl                                       |
// | Purpose   : Self-checking bench for pipe_stall_ctrl: directed        |
// |             scenarios plus random traffic against a cycle model.     |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_pipe_stall_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, haz = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
  logic pc_stall, ifid_stall, ifid_flush, idex_flush, mem_stall, err;
  logic [CNT_W-1:0] stall_cnt, hazard_cnt;
  logic [5:0] w_outs;

  int n_vec = 0;
  int n_mis = 0;

  // Model: running flag, sticky error, consecutive stalled cycles, counts.
  int m_on, m_err, m_run, m_scnt, m_hcnt;
  logic [5:0]       exp_o;
  logic [CNT_W-1:0] exp_s, exp_h;

  always #5 clk = ~clk;

  assign w_outs = {pc_stall, ifid_stall, ifid_flush, idex_flush, mem_stall, err};

  pipe_stall_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (start),
    .hazard_i     (haz),
    .branch_i     (br),
    .mem_req_i    (req),
    .mem_ack_i    (ack),
    .pc_stall_o   (pc_stall),
    .ifid_stall_o (ifid_stall),
    .ifid_flush_o (ifid_flush),
    .idex_flush_o (idex_flush),
    .mem_stall_o  (mem_stall),
    .error_o      (err),
    .stall_cnt_o  (stall_cnt),
    .hazard_cnt_o (hazard_cnt)
  );

  // Expected outputs {pc, ifid, ifid_flush, idex_flush, mem_stall, error}.
  task automatic model_eval();
    logic miss;
    if (m_err != 0)      exp_o = 6'b110011;
    else if (m_on == 0)  exp_o = 6'b110010;
    else begin
      miss = (m_run == 0) ? (req & ~ack) : ~ack;
      if (miss)       exp_o = 6'b110010;
      else if (haz)   exp_o = 6'b110100;
      else if (br)    exp_o = 6'b001000;
      else            exp_o = 6'b000000;
    end
    exp_s = PERF ? CNT_W'(m_scnt) : '0;
    exp_h = PERF ? CNT_W'(m_hcnt) : '0;
  endtask

  task automatic model_step();
    if (m_err != 0) begin
    end else if (m_on == 0) begin
      m_on = start ? 1 : 0;
    end else begin
      if (exp_o[1] && m_scnt < SAT) m_scnt++;
      if (exp_o[2] && m_hcnt < SAT) m_hcnt++;
      if (!start) begin
        m_on = 0; m_run = 0;
      end else if (exp_o[1]) begin
        if (m_run == TIMEOUT) m_err = 1;
        else m_run++;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic drive(input logic s, h, b, rq, ak);
    @(negedge clk);
    start = s; haz = h; br = b; req = rq; ack = ak;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; haz = 0; br = 0; req = 0; ack = 0;
    #2 rst_n = 1'b0;
    m_on = 0; m_err = 0; m_run = 0; m_scnt = 0; m_hcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (w_outs !== 6'b110010) begin
      n_mis++; $display("FAIL reset outs got=%b want=110010", w_outs);
    end
    n_vec++;
    if (stall_cnt !== '0 || hazard_cnt !== '0) begin
      n_mis++; $display("FAIL reset cnt got=%0d/%0d want=0/0", stall_cnt, hazard_cnt);
    end
    tick();
  endtask

  task automatic test_start();
    logic [3:0] s_tab = 4'b1000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive((i < 4) ? s_tab[i] : 1'b1, 0, 0, 0, 0);
      n_vec++;
      if (w_outs !== exp_o) begin
        n_mis++; $display("FAIL start[%0d] outs got=%b want=%b", i, w_outs, exp_o);
      end
      if (i == 4) begin
        n_vec++;
        if (w_outs !== 6'b000000) begin
          n_mis++; $display("FAIL start_run outs got=%b want=000000", w_outs);
        end
      end
      tick();
    end
  endtask

  task automatic test_hazard_branch();
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 0, 0);
    n_vec++;
    if (w_outs !== 6'b110100 || w_outs !== exp_o) begin
      n_mis++; $display("FAIL haz_br outs got=%b want=110100", w_outs);
    end
    tick();
    drive(1, 0, 1, 0, 0);
    n_vec++;
    if (w_outs !== 6'b001000 || w_outs !== exp_o) begin
      n_mis++; $display("FAIL branch outs got=%b want=001000", w_outs);
    end
    n_vec++;
    if (hazard_cnt !== (PERF ? CNT_W'(1) : '0) || hazard_cnt !== exp_h) begin
      n_mis++; $display("FAIL haz_cnt got=%0d want=%0d", hazard_cnt, exp_h);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, (i == 3));
      n_vec++;
      if (mem_stall !== (i < 3) || w_outs !== exp_o) begin
        n_mis++; $display("FAIL mem_wait[%0d] outs got=%b want=%b", i, w_outs, exp_o);
      end
      tick();
    end
    drive(1, 0, 0, 0, 0);
    n_vec++;
    if (w_outs !== 6'b000000) begin
      n_mis++; $display("FAIL mem_back_run outs got=%b want=000000", w_outs);
    end
    n_vec++;
    if (stall_cnt !== (PERF ? CNT_W'(3) : '0) || stall_cnt !== exp_s) begin
      n_mis++; $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, exp_s);
    end
    tick();
  endtask

  task automatic test_ack_hazard();
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0); tick();
    drive(1, 1, 0, 1, 1);
    n_vec++;
    if (w_outs !== 6'b110100 || w_outs !== exp_o) begin
      n_mis++; $display("FAIL ack_hazard outs got=%b want=110100", w_outs);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      drive(1, 0, 0, 1, 0);
      n_vec++;
      if (w_outs !== 6'b110010 || w_outs !== exp_o) begin
        n_mis++; $display("FAIL tmo_stall[%0d] outs got=%b want=110010", i, w_outs);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(i[0], 0, 0, 1, 0);
      n_vec++;
      if (w_outs !== 6'b110011 || w_outs !== exp_o) begin
        n_mis++; $display("FAIL tmo_err[%0d] outs got=%b want=110011", i, w_outs);
      end
      tick();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (err !== 1'b0) begin
      n_mis++; $display("FAIL tmo_clear err got=%b want=0", err);
    end
    m_on = 0; m_err = 0; m_run = 0; m_scnt = 0; m_hcnt = 0;
    @(negedge clk);
    start = 0; req = 0; rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (w_outs !== 6'b110010) begin
      n_mis++; $display("FAIL async_rst outs got=%b want=110010", w_outs);
    end
    n_vec++;
    if (stall_cnt !== '0 || hazard_cnt !== '0) begin
      n_mis++; $display("FAIL async_rst cnt got=%0d/%0d want=0/0", stall_cnt, hazard_cnt);
    end
    m_on = 0; m_err = 0; m_run = 0; m_scnt = 0; m_hcnt = 0;
    @(negedge clk);
    start = 0; req = 0; rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_err != 0 && $urandom_range(0, 5) == 0) begin
        do_reset();
      end
      drive($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) < 2,
            $urandom_range(0, 1) == 1);
      n_vec++;
      if (w_outs !== exp_o) begin
        n_mis++; $display("FAIL rand[%0d] outs got=%b want=%b", i, w_outs, exp_o);
      end
      n_vec++;
      if (stall_cnt !== exp_s || hazard_cnt !== exp_h) begin
        n_mis++; $display("FAIL rand[%0d] cnt got=%0d/%0d want=%0d/%0d",
                          i, stall_cnt, hazard_cnt, exp_s, exp_h);
      end
      tick();
    end
  endtask

  initial begin
    m_on = 0; m_err = 0; m_run = 0; m_scnt = 0; m_hcnt = 0;
    exp_o = '0; exp_s = '0; exp_h = '0;
    test_reset();
    test_start();
    test_hazard_branch();
    test_mem_wait();
    test_ack_hazard();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
